// File: rtl/instr_fetch_pkg.sv
// Types and constants shared by the fetch stage and decode.
// Holds the fetch FSM encoding, the queue entry layout and the PC increment helper.
package instr_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/instr_fetch_queue.sv
// fetch_queue: DEPTH-entry synchronous FIFO of {instr, pc}; pushed data is visible at the head
// the cycle after the push edge. A push into a full queue is dropped unless a pop happens too.
module fetch_queue
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_push,
    input  logic [2*XLEN-1:0]   i_push_dat,
    input  logic                i_pop,
    input  logic                i_flush,
    output logic                o_full,
    output logic                o_empty,
    output logic [CW-1:0]       o_count,
    output logic [2*XLEN-1:0]   o_head_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2*XLEN-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [2*XLEN-1:0] r_last;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // An empty queue keeps showing the last head so decode sees stable (but invalid) data.
    assign o_head_dat = o_empty ? r_last : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= o_head_dat;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
            r_last  <= o_head_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, single-outstanding imem req/ack, DEPTH-entry output queue; word visible one cycle
// after its ack edge. Stops requesting while the queue is full; redirects flush and may drain one stale ack.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    output logic            o_instr_valid,
    input  logic            i_instr_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_fault
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] r_pc;

    logic            w_redirect_ok;
    logic            w_misaligned;
    logic            w_redirect_go;
    logic            w_ack_take;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_count_after;
    logic            w_room_after;
    fetch_entry_t    w_push_ent;
    fetch_entry_t    w_head_ent;

    // Redirects are dead once halted; a misaligned target halts instead of moving the PC.
    assign w_redirect_ok = i_redirect & (r_state != ST_HALT);
    assign w_misaligned  = (i_redirect_pc[1:0] != 2'b00);
    assign w_redirect_go = w_redirect_ok & ~w_misaligned;

    assign w_ack_take = (r_state == ST_REQ) & i_imem_ack;
    assign w_push     = w_ack_take & ~w_redirect_ok;
    assign w_pop      = i_instr_ready & ~w_redirect_ok;

    assign w_count_after = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop & ~w_empty);
    assign w_room_after  = (w_count_after < (CW+1)'(DEPTH));

    assign w_push_ent.instr = i_imem_rdata;
    assign w_push_ent.pc    = r_pc;

    fetch_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_queue (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (w_push),
        .i_push_dat (w_push_ent),
        .i_pop      (w_pop),
        .i_flush    (w_redirect_ok),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_head_dat (w_head_ent)
    );

    assign o_instr       = w_head_ent.instr;
    assign o_instr_pc    = w_head_ent.pc;
    assign o_instr_valid = ~w_empty;
    assign o_imem_addr   = r_pc;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_redirect_ok && w_misaligned) begin
                    w_state_nxt = ST_HALT;
                end else if (w_redirect_ok || !w_full) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_redirect_ok && w_misaligned) begin
                    w_state_nxt = ST_HALT;
                end else if (w_redirect_ok) begin
                    // Without a same-cycle ack the killed request is still in flight.
                    w_state_nxt = i_imem_ack ? ST_REQ : ST_DRAIN;
                end else if (i_imem_ack) begin
                    w_state_nxt = w_room_after ? ST_REQ : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_redirect_ok && w_misaligned) begin
                    w_state_nxt = ST_HALT;
                end else if (i_imem_ack) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
    end

    always_comb begin
        o_imem_req = 1'b0;
        o_fault    = 1'b0;
        case (r_state)
            ST_REQ:  o_imem_req = 1'b1;
            ST_HALT: o_fault    = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc <= RESET_PC;
        end else if (w_redirect_go) begin
            r_pc <= i_redirect_pc;
        end else if (w_push) begin
            r_pc <= pc_next(r_pc);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder with programmable latency, expected-word scoreboard per scenario.
module tb_instr_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fault;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_instr_pc;
    logic        w_valid;
    logic        w_ready;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_fault;

    int          vectors = 0;
    int          miscompares = 0;
    int          mem_lat = 1;
    bit          busy = 1'b0;
    int          cnt = 0;
    logic [31:0] pend_addr;
    logic [31:0] req_log[$];
    logic [31:0] ack_log[$];
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (imem_ack),
        .i_imem_rdata  (imem_rdata),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (instr_valid),
        .i_instr_ready (instr_ready),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_fault       (fault)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) u_wrap (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .o_imem_req    (w_req),
        .o_imem_addr   (w_addr),
        .i_imem_ack    (w_ack),
        .i_imem_rdata  (w_rdata),
        .o_instr       (w_instr),
        .o_instr_pc    (w_instr_pc),
        .o_instr_valid (w_valid),
        .i_instr_ready (w_ready),
        .i_redirect    (w_redirect),
        .i_redirect_pc (w_redirect_pc),
        .o_fault       (w_fault)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00A0_0093;
            32'h0000_0004: return 32'h0010_0113;
            32'h0000_0008: return 32'hDEAD_BEEF;
            default:       return a ^ 32'h5A5A_0013;
        endcase
    endfunction

    // Instruction memory: latches each new request, acks mem_lat cycles later (0 = same cycle).
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
            end else if (busy) begin
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(pend_addr);
                    ack_log.push_back(pend_addr);
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (imem_req) begin
                pend_addr = imem_addr;
                req_log.push_back(imem_addr);
                if (mem_lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(pend_addr);
                    ack_log.push_back(pend_addr);
                end else begin
                    busy = 1'b1;
                    cnt  = mem_lat - 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        w_ack       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        req_log.delete();
        ack_log.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 00000000", instr); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_instr_pc: got %h want 00000000", instr_pc); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fault); end
        vectors++; if (w_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL reset_wrap_addr: got %h want fffffffc", w_addr); end
    endtask

    task automatic test_basic();
        exp_t e;
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        e.pc = 32'h0; e.instr = mem_word(32'h0); exp_q.push_back(e);
        e.pc = 32'h4; e.instr = mem_word(32'h4); exp_q.push_back(e);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                vectors++;
                if (instr !== e.instr || instr_pc !== e.pc) begin
                    miscompares++;
                    $display("FAIL basic_word: got %h@%h want %h@%h", instr, instr_pc, e.instr, e.pc);
                end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL basic_timeout: %0d words missing, want 0", exp_q.size()); end
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (req_log.size() < 2 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4) begin
            miscompares++;
            $display("FAIL basic_addr_seq: got %0d reqs first %h want 00000000,00000004", req_log.size(),
                     (req_log.size() > 0) ? req_log[0] : 32'hx);
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b0;
        repeat (20) @(negedge clk);
        vectors++; if (ack_log.size() != 2) begin miscompares++; $display("FAIL bp_ack_count: got %0d want 2", ack_log.size()); end
        vectors++; if (ack_log.size() < 2 || ack_log[0] !== 32'h0 || ack_log[1] !== 32'h4) begin miscompares++; $display("FAIL bp_ack_addrs: got size %0d want 0,4", ack_log.size()); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_full: got %b want 0", imem_req); end
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin miscompares++; $display("FAIL bp_head: got %b %h@%h want 1 %h@00000000", instr_valid, instr, instr_pc, mem_word(32'h0)); end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        repeat (6) @(negedge clk);
        vectors++; if (ack_log.size() != 3 || ack_log[2] !== 32'h8) begin miscompares++; $display("FAIL bp_resume: got %0d acks want 3 ending at 00000008", ack_log.size()); end
        vectors++; if (instr_pc !== 32'h4 || instr !== mem_word(32'h4)) begin miscompares++; $display("FAIL bp_head2: got %h@%h want %h@00000004", instr, instr_pc, mem_word(32'h4)); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_refull: got %b want 0", imem_req); end
    endtask

    task automatic test_redirect_drain();
        exp_t e;
        bit   found;
        bit   saw_bad;
        int   n8;
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b0;
        repeat (12) @(negedge clk);
        mem_lat = 3;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL drain_req8: got no request want 00000008"); end
        @(negedge clk);
        n8 = req_log.size();
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL drain_flush: got valid %b want 0", instr_valid); end
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL drain_state: got req %b addr %h want 0 00000100", imem_req, imem_addr); end
        e.pc = 32'h100; e.instr = mem_word(32'h100); exp_q.push_back(e);
        e.pc = 32'h104; e.instr = mem_word(32'h104); exp_q.push_back(e);
        instr_ready = 1'b1;
        saw_bad = 1'b0;
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr === 32'hDEAD_BEEF) saw_bad = 1'b1;
            if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                vectors++;
                if (instr !== e.instr || instr_pc !== e.pc) begin
                    miscompares++;
                    $display("FAIL drain_word: got %h@%h want %h@%h", instr, instr_pc, e.instr, e.pc);
                end
            end
        end
        instr_ready = 1'b0;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL drain_timeout: %0d words missing, want 0", exp_q.size()); end
        vectors++; if (saw_bad) begin miscompares++; $display("FAIL drain_stale: got deadbeef at decode want never"); end
        vectors++; if (req_log.size() <= n8 || req_log[n8] !== 32'h100) begin miscompares++; $display("FAIL drain_next_addr: got %0d reqs want req %0d at 00000100", req_log.size(), n8); end
    endtask

    task automatic test_redirect_ack_pop();
        exp_t e;
        bit   found;
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h4) begin
                found = 1'b1;
                break;
            end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL rap_req4: got no request want 00000004"); end
        @(negedge clk);
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL rap_pre_valid: got %b want 1", instr_valid); end
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        instr_ready = 1'b1;
        @(negedge clk);
        redirect    = 1'b0;
        instr_ready = 1'b0;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rap_flush: got valid %b want 0", instr_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL rap_next_req: got %b %h want 1 00000200", imem_req, imem_addr); end
        vectors++; if (ack_log.size() < 2 || ack_log[1] !== 32'h4) begin miscompares++; $display("FAIL rap_ack_seen: got %0d acks want ack of 00000004", ack_log.size()); end
        e.pc = 32'h200; e.instr = mem_word(32'h200); exp_q.push_back(e);
        e.pc = 32'h204; e.instr = mem_word(32'h204); exp_q.push_back(e);
        instr_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                vectors++;
                if (instr !== e.instr || instr_pc !== e.pc) begin
                    miscompares++;
                    $display("FAIL rap_word: got %h@%h want %h@%h", instr, instr_pc, e.instr, e.pc);
                end
            end
        end
        instr_ready = 1'b0;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL rap_timeout: %0d words missing, want 0", exp_q.size()); end
    endtask

    task automatic test_misaligned();
        exp_t e;
        int   bad;
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        repeat (6) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        vectors++; if (fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL mis_halt: got fault %b req %b valid %b want 1 0 0", fault, imem_req, instr_valid); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || fault !== 1'b1) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL mis_sticky: got %0d bad cycles want 0", bad); end
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        @(negedge clk);
        redirect = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (imem_req !== 1'b0 || fault !== 1'b1 || instr_valid !== 1'b0) bad++;
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL mis_redirect_ignored: got %0d bad cycles want 0", bad); end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (fault !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mis_reset_clear: got fault %b addr %h want 0 00000000", fault, imem_addr); end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        e.pc = 32'h0; e.instr = mem_word(32'h0); exp_q.push_back(e);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                vectors++;
                if (instr !== e.instr || instr_pc !== e.pc) begin
                    miscompares++;
                    $display("FAIL mis_restart_word: got %h@%h want %h@%h", instr, instr_pc, e.instr, e.pc);
                end
            end
        end
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL mis_restart_timeout: %0d words missing, want 0", exp_q.size()); end
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        mem_lat = 3;
        do_reset();
        instr_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h4) begin
                found = 1'b1;
                break;
            end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL mid_req4: got no request want 00000004"); end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_reset_req: got %b %h want 0 00000000", imem_req, imem_addr); end
        vectors++; if (instr_valid !== 1'b0 || instr !== 32'h0) begin miscompares++; $display("FAIL mid_reset_out: got %b %h want 0 00000000", instr_valid, instr); end
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap();
        bit found;
        mem_lat = 1;
        do_reset();
        w_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (w_req && w_addr == 32'hFFFF_FFFC) begin
                found = 1'b1;
                break;
            end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL wrap_first_req: got no request want fffffffc"); end
        w_ack   = 1'b1;
        w_rdata = 32'h0000_0113;
        @(negedge clk);
        w_ack = 1'b0;
        vectors++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next_addr: got %b %h want 1 00000000", w_req, w_addr); end
        vectors++; if (w_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFFC || w_instr !== 32'h0000_0113) begin miscompares++; $display("FAIL wrap_head: got %b %h@%h want 1 00000113@fffffffc", w_valid, w_instr, w_instr_pc); end
        w_ack   = 1'b1;
        w_rdata = 32'h0000_0213;
        @(negedge clk);
        w_ack = 1'b0;
        vectors++; if (w_req !== 1'b0 || w_addr !== 32'h4 || w_fault !== 1'b0) begin miscompares++; $display("FAIL wrap_full: got req %b addr %h fault %b want 0 00000004 0", w_req, w_addr, w_fault); end
        vectors++; if (w_instr_pc !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_head_hold: got %h want fffffffc", w_instr_pc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        instr_ready   = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        w_ack         = 1'b0;
        w_rdata       = 32'h0;
        w_ready       = 1'b0;
        w_redirect    = 1'b0;
        w_redirect_pc = 32'h0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_drain();
        test_redirect_ack_pop();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
